// File: rtl/pipe_mux_packetizer.sv
`default_nettype none
// ============================================================================
// Module      : pipe_mux_packetizer
// Description : Merges CHANNELS sys-side streams into one packetised pipe-out
//               stream. Each channel owns a synchronous FIFO; a round-robin
//               arbiter emits a header word (channel, length) followed by up
//               to BURST payload words taken from the granted FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_mux_packetizer #(
  parameter int CHANNELS   = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 6,
  parameter int BURST      = 16
) (
  input  logic                               sys_clk,
  input  logic                               sys_rst_n,
  input  logic [CHANNELS-1:0]                in_valid,
  output logic [CHANNELS-1:0]                in_ready,
  input  logic [CHANNELS*DATA_WIDTH-1:0]     in_data,
  output logic [CHANNELS*(ADDR_WIDTH+1)-1:0] in_count,
  input  logic                               out_ready,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  output logic                               out_last,
  output logic                               busy
);

  localparam int CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CNTW  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HEADER  = 2'd1,
    S_PAYLOAD = 2'd2
  } state_t;

  state_t                            r_state;
  logic [CW-1:0]                     r_chan;
  logic [CW-1:0]                     r_grant;
  logic [7:0]                        r_rem;
  logic                              r_out_valid;
  logic                              r_out_last;
  logic [DATA_WIDTH-1:0]             r_out_data;

  logic [CHANNELS-1:0][CNTW-1:0]       w_count;
  logic [CHANNELS-1:0][DATA_WIDTH-1:0] w_head;
  logic                              w_pop_any;
  logic                              w_found;
  logic [CW-1:0]                     w_sel;
  logic [7:0]                        w_len;
  logic [DATA_WIDTH-1:0]             w_hdr;
  logic [DATA_WIDTH-1:0]             w_head_sel;

  // A pop loads the next payload word into the output register: on header
  // acceptance and on every payload acceptance except the final one.
  assign w_pop_any = out_ready &
                     ((r_state == S_HEADER) |
                      ((r_state == S_PAYLOAD) & (r_rem != 8'd1)));

  generate
    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      logic [DATA_WIDTH-1:0] r_mem [DEPTH];
      logic [ADDR_WIDTH-1:0] r_wptr;
      logic [ADDR_WIDTH-1:0] r_rptr;
      logic [CNTW-1:0]       r_cnt;
      logic                  w_push;
      logic                  w_pop;
      logic                  w_full;

      assign w_full      = (r_cnt == CNTW'(DEPTH));
      assign in_ready[c] = ~w_full & sys_rst_n;
      assign w_push      = in_valid[c] & in_ready[c];
      assign w_pop       = w_pop_any & (r_chan == CW'(c));
      assign w_count[c]  = r_cnt;
      assign w_head[c]   = r_mem[r_rptr];

      // FIFO storage; contents need no reset since the count gates reads
      always_ff @(posedge sys_clk) begin
        if (w_push) r_mem[r_wptr] <= in_data[c*DATA_WIDTH +: DATA_WIDTH];
      end

      // FIFO pointers and occupancy; push+pop together leaves count unchanged
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          r_wptr <= '0;
          r_rptr <= '0;
          r_cnt  <= '0;
        end else begin
          if (w_push) r_wptr <= r_wptr + 1'b1;
          if (w_pop)  r_rptr <= r_rptr + 1'b1;
          case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: r_cnt <= r_cnt;
          endcase
        end
      end
    end
  endgenerate

  assign in_count   = w_count;
  assign w_head_sel = w_head[r_chan];

  // Round-robin scan from grant+1; iterating backwards lets the nearest hit win
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    for (int i = CHANNELS; i >= 1; i--) begin
      if (w_count[(int'(r_grant) + i) % CHANNELS] != '0) begin
        w_found = 1'b1;
        w_sel   = CW'((int'(r_grant) + i) % CHANNELS);
      end
    end
  end

  // Packet length is the selected occupancy clamped to BURST; header layout
  always_comb begin
    w_len = (int'(w_count[w_sel]) > BURST) ? 8'(BURST) : 8'(w_count[w_sel]);
    w_hdr = '0;
    w_hdr[DATA_WIDTH-1 -: 8] = 8'(w_sel);
    w_hdr[7:0]               = w_len;
  end

  // Packet FSM with registered output word, valid and last flags
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state     <= S_IDLE;
      r_chan      <= '0;
      r_grant     <= CW'(CHANNELS - 1);
      r_rem       <= '0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_chan      <= w_sel;
            r_rem       <= w_len;
            r_out_data  <= w_hdr;
            r_out_valid <= 1'b1;
            r_out_last  <= 1'b0;
            r_state     <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (out_ready) begin
            r_out_data <= w_head_sel;
            r_out_last <= (r_rem == 8'd1);
            r_state    <= S_PAYLOAD;
          end
        end
        S_PAYLOAD: begin
          if (out_ready) begin
            if (r_rem == 8'd1) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_grant     <= r_chan;
              r_state     <= S_IDLE;
            end else begin
              r_out_data <= w_head_sel;
              r_rem      <= r_rem - 8'd1;
              r_out_last <= (r_rem == 8'd2);
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_last  = r_out_last;
  assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire
